// File: rtl/reg_pkg.sv
// ---------------------------------------------------------------------------
// reg_pkg
//   Shared sizing for the register file with scoreboard (reg_file_sb).
//   Holds the default data/address widths and derives the register count
//   from the address width, so every file sizes its arrays the same way.
//
//   Contents:
//     DATA_W_DEF  default register/data width in bits
//     ADDR_W_DEF  default register address width in bits
//     NUM_REGS    register count for the default address width
//     numRegs()   register count for an arbitrary address width
// ---------------------------------------------------------------------------
package reg_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;

    // Every address value names a register, including the hard-wired r0.
    function automatic int numRegs(input int addrW);
        return 1 << addrW;
    endfunction

    localparam int NUM_REGS = numRegs(ADDR_W_DEF);

endpackage : reg_pkg

// File: rtl/reg_file_sb_if.sv
// ---------------------------------------------------------------------------
// reg_file_sb_if
//   Bundles the read, writeback and issue signals of the register file.
//   The pipeline side uses the master modport; reg_file_sb uses slave.
//
//   Signals:
//     REG_address1/2     read port addresses
//     REG_data_out1/2    read port data (combinational, bypassed)
//     REG_busy1/2        addressed register has an unresolved producer
//     REG_hazard         REG_busy1 | REG_busy2
//     REG_write_1        writeback enable
//     REG_address_wr     writeback address
//     REG_data_wb_in1    writeback data
//     REG_issue          mark REG_issue_address as pending
//     REG_issue_address  destination of the issued instruction
// ---------------------------------------------------------------------------
interface reg_file_sb_if
    import reg_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
);

    logic [ADDR_W-1:0] REG_address1;
    logic [ADDR_W-1:0] REG_address2;
    logic [DATA_W-1:0] REG_data_out1;
    logic [DATA_W-1:0] REG_data_out2;
    logic              REG_busy1;
    logic              REG_busy2;
    logic              REG_hazard;
    logic              REG_write_1;
    logic [ADDR_W-1:0] REG_address_wr;
    logic [DATA_W-1:0] REG_data_wb_in1;
    logic              REG_issue;
    logic [ADDR_W-1:0] REG_issue_address;

    modport master (
        output REG_address1,
        output REG_address2,
        input  REG_data_out1,
        input  REG_data_out2,
        input  REG_busy1,
        input  REG_busy2,
        input  REG_hazard,
        output REG_write_1,
        output REG_address_wr,
        output REG_data_wb_in1,
        output REG_issue,
        output REG_issue_address
    );

    modport slave (
        input  REG_address1,
        input  REG_address2,
        output REG_data_out1,
        output REG_data_out2,
        output REG_busy1,
        output REG_busy2,
        output REG_hazard,
        input  REG_write_1,
        input  REG_address_wr,
        input  REG_data_wb_in1,
        input  REG_issue,
        input  REG_issue_address
    );

endinterface : reg_file_sb_if

// File: rtl/reg_scoreboard.sv
// ---------------------------------------------------------------------------
// reg_scoreboard
//   One busy bit per register marking a pending, unresolved producer.
//   Issue sets the destination bit, writeback clears it; when both hit the
//   same register on one edge the new producer wins and the bit stays set.
//   The read-side busy flags are masked by a same-cycle writeback to the
//   read address, since that value is being bypassed to the reader now.
//
//   Ports:
//     clock, reset_n  clock and asynchronous active-low reset
//     wrEn_i          writeback enable
//     wrAddr_i        writeback address
//     issue_i         issue strobe
//     issueAddr_i     issued destination register
//     rdAddr1_i/2_i   read port addresses
//     busy1_o/2_o     busy flag for each read port
//     hazard_o        either read port busy
// ---------------------------------------------------------------------------
module reg_scoreboard
    import reg_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              wrEn_i,
    input  logic [ADDR_W-1:0] wrAddr_i,
    input  logic              issue_i,
    input  logic [ADDR_W-1:0] issueAddr_i,
    input  logic [ADDR_W-1:0] rdAddr1_i,
    input  logic [ADDR_W-1:0] rdAddr2_i,
    output logic              busy1_o,
    output logic              busy2_o,
    output logic              hazard_o
);

    localparam int NREGS = numRegs(ADDR_W);

    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;
    logic             wbValid;
    logic             issueValid;
    logic             hit1;
    logic             hit2;

    // r0 is never a real destination, so neither strobe may touch it.
    assign wbValid    = wrEn_i  && (wrAddr_i    != '0);
    assign issueValid = issue_i && (issueAddr_i != '0);

    assign hit1 = wbValid && (wrAddr_i == rdAddr1_i);
    assign hit2 = wbValid && (wrAddr_i == rdAddr2_i);

    // Clear first, then set: a same-register issue overrides the writeback.
    always_comb begin
        busy_d = busy_q;
        if (wbValid) begin
            busy_d[wrAddr_i] = 1'b0;
        end
        if (issueValid) begin
            busy_d[issueAddr_i] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    // busy_q[0] is held at zero, so address 0 never reports busy.
    assign busy1_o  = busy_q[rdAddr1_i] && !hit1;
    assign busy2_o  = busy_q[rdAddr2_i] && !hit2;
    assign hazard_o = busy1_o || busy2_o;

endmodule : reg_scoreboard

// File: rtl/reg_file_sb.sv
// ---------------------------------------------------------------------------
// reg_file_sb
//   Two-read, one-write register file with a writeback bypass and a
//   per-register busy scoreboard. r0 is hard-wired to zero. Reads are
//   combinational; a writeback to the addressed register is forwarded to
//   the read port in the same cycle.
//
//   Ports:
//     clock    single clock, all state updates on the rising edge
//     reset_n  asynchronous active-low reset, clears data and busy bits
//     bus      reg_file_sb_if.slave (read ports, writeback, issue, busy)
// ---------------------------------------------------------------------------
module reg_file_sb
    import reg_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic         clock,
    input  logic         reset_n,
    reg_file_sb_if.slave bus
);

    localparam int NREGS = numRegs(ADDR_W);

    logic [DATA_W-1:0] regs_q [NREGS];
    logic              wbValid;
    logic              bypass1;
    logic              bypass2;

    assign wbValid = bus.REG_write_1 && (bus.REG_address_wr != '0);
    assign bypass1 = wbValid && (bus.REG_address_wr == bus.REG_address1);
    assign bypass2 = wbValid && (bus.REG_address_wr == bus.REG_address2);

    // Storage. regs_q[0] is only ever reset, which keeps r0 at zero without
    // a separate read-side mux.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wbValid) begin
            regs_q[bus.REG_address_wr] <= bus.REG_data_wb_in1;
        end
    end

    // Read ports with writeback forwarding. Forwarding is purely
    // combinational, so it still applies while reset is held.
    assign bus.REG_data_out1 = bypass1 ? bus.REG_data_wb_in1 : regs_q[bus.REG_address1];
    assign bus.REG_data_out2 = bypass2 ? bus.REG_data_wb_in1 : regs_q[bus.REG_address2];

    reg_scoreboard #(
        .ADDR_W (ADDR_W)
    ) u_scoreboard (
        .clock       (clock),
        .reset_n     (reset_n),
        .wrEn_i      (bus.REG_write_1),
        .wrAddr_i    (bus.REG_address_wr),
        .issue_i     (bus.REG_issue),
        .issueAddr_i (bus.REG_issue_address),
        .rdAddr1_i   (bus.REG_address1),
        .rdAddr2_i   (bus.REG_address2),
        .busy1_o     (bus.REG_busy1),
        .busy2_o     (bus.REG_busy2),
        .hazard_o    (bus.REG_hazard)
    );

endmodule : reg_file_sb

// File: doc/reg_file_sb.md
REG_FILE_SB -- requirements
Module: reg_file_sb

Interface
REQ-001 Parameter DATA_W, default 32, register and data width in bits.
REQ-002 Parameter ADDR_W, default 5, register address width; register count NUM_REGS = 2**ADDR_W.
REQ-003 clock  input  1  single clock; all state updates on rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 REG_address1  input  ADDR_W  read port 1 address.
REQ-006 REG_address2  input  ADDR_W  read port 2 address.
REQ-007 REG_data_out1  output  DATA_W  read port 1 data, combinational.
REQ-008 REG_data_out2  output  DATA_W  read port 2 data, combinational.
REQ-009 REG_busy1  output  1  register at REG_address1 has a pending, unresolved producer.
REQ-010 REG_busy2  output  1  same as REG_busy1, for REG_address2.
REQ-011 REG_hazard  output  1  REG_busy1 OR REG_busy2.
REQ-012 REG_write_1  input  1  writeback enable.
REQ-013 REG_address_wr  input  ADDR_W  writeback address.
REQ-014 REG_data_wb_in1  input  DATA_W  writeback data.
REQ-015 REG_issue  input  1  marks the destination register as pending (scoreboard set).
REQ-016 REG_issue_address  input  ADDR_W  destination register of the issued instruction.

Function
REQ-017 Register 0 SHALL read as 0 at all times; writes and issues to address 0 are ignored.
REQ-018 On a rising edge with REG_write_1=1 and REG_address_wr!=0, register[REG_address_wr] SHALL take REG_data_wb_in1.
REQ-019 Read ports SHALL bypass: when REG_write_1=1, REG_address_wr!=0 and it equals the read address, REG_data_outN SHALL equal REG_data_wb_in1 in the same cycle.
REQ-020 Otherwise REG_data_outN SHALL equal register[REG_address N], with zero cycles of latency.
REQ-021 Each register 1..NUM_REGS-1 SHALL have a busy bit; on a rising edge, REG_issue=1 with a nonzero address SHALL set busy[REG_issue_address].
REQ-022 On a rising edge, a qualifying writeback (REQ-018) SHALL clear busy[REG_address_wr].
REQ-023 A simultaneous issue and writeback to the same address SHALL leave the busy bit set; the new producer wins.
REQ-024 A simultaneous issue and writeback to different addresses SHALL set and clear their respective bits independently.
REQ-025 Issue to an already-busy register SHALL keep it busy (a single bit, no counting).
REQ-026 REG_busyN SHALL be busy[REG_address N] AND NOT (same-cycle bypass hit on that address); REG_busyN SHALL be 0 for address 0.
REQ-027 Both read ports SHALL be fully independent and may address the same register.

Reset
REQ-028 While reset_n=0, all registers and all busy bits SHALL be 0, regardless of clock.
REQ-029 During reset, outputs SHALL be: REG_data_out1/2 = 0 unless a bypass hit applies, REG_busy1/2 = 0, REG_hazard = 0.
REQ-030 Assertion of reset in the middle of operation SHALL discard any same-edge write or issue; the first update SHALL be taken on the first rising edge after reset_n rises.

Structure
REQ-031 Package reg_pkg SHALL hold the DATA_W/ADDR_W defaults and the NUM_REGS derivation.
REQ-032 Scoreboard bits and the REG_busyN logic SHALL live in sub-module reg_scoreboard; storage and bypass logic SHALL stay in reg_file_sb.
REQ-033 Storage SHALL be a parametrised array; there are no per-register hand-enumerated declarations.

Verification
REQ-034 Reset, then read addresses 0..31 -> all data 0, busy 0, hazard 0.
REQ-035 Write 0xDEADBEEF to r5; in the same cycle read r5 -> out1=0xDEADBEEF (bypass); next cycle with write off -> still 0xDEADBEEF.
REQ-036 Write 0x1234 to r0, then read r0 -> 0; issue r0 -> busy stays 0.
REQ-037 Issue r7; next cycle read r7 -> busy1=1, hazard=1; writeback r7=0x55 -> busy1=0 in that same cycle, out1=0x55; next cycle busy1=0.
REQ-038 Issue r9 and writeback r9 on the same edge -> busy[9]=1 afterward; issue r3 and writeback r4 on the same edge with r4 busy -> r3 busy, r4 clear.
REQ-039 Fill r1..r3 and set busy on r1..r3, then pulse reset_n low between edges -> immediate zero data and busy; a write on the edge during reset is not applied.
